// File: rtl/alu_sequencer_pkg.sv
// rtl/alu_sequencer_pkg.sv - shared encodings for the ALU sequencer
package alu_sequencer_pkg;

    localparam int DATA_W  = 16;
    localparam int ADDR_W  = 3;
    localparam int NUM_REG = 8;
    localparam int INSTR_W = 16;

    localparam int OP_MSB = 15;
    localparam int OP_LSB = 12;
    localparam int RA_MSB = 11;
    localparam int RA_LSB = 9;
    localparam int RB_MSB = 8;
    localparam int RB_LSB = 6;
    localparam int D_MSB  = 5;
    localparam int D_LSB  = 2;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_CMP  = 4'b0101;
    localparam logic [3:0] OP_MOV  = 4'b0110;
    localparam logic [3:0] OP_IDLE = 4'b0111;
    localparam logic [3:0] OP_SLL  = 4'b1000;
    localparam logic [3:0] OP_SRL  = 4'b1001;
    localparam logic [3:0] OP_ROL  = 4'b1010;
    localparam logic [3:0] OP_SRA  = 4'b1011;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DECODE = 2'd1,
        ST_EXEC   = 2'd2,
        ST_WB     = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        WB_REG_FLAGS = 2'd0,
        WB_FLAGS     = 2'd1,
        WB_ILLEGAL   = 2'd2
    } wb_kind_e;

    // 0111 doubles as the idle opcode shown to the ALU, so it can never retire as legal.
    function automatic wb_kind_e classify_op(input logic [3:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_MOV,
            OP_SLL, OP_SRL, OP_ROL, OP_SRA: return WB_REG_FLAGS;
            OP_CMP:                         return WB_FLAGS;
            default:                        return WB_ILLEGAL;
        endcase
    endfunction

endpackage

// File: rtl/alu_regfile.sv
// rtl/alu_regfile.sv - 8x16 register file, one write port, three async read ports
module alu_regfile
    import alu_sequencer_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr_a,
    output logic [DATA_W-1:0] rdata_a,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [DATA_W-1:0] rdata_b,
    input  logic [ADDR_W-1:0] raddr_c,
    output logic [DATA_W-1:0] rdata_c
);

    logic [DATA_W-1:0] regs_q [NUM_REG];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REG; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we) begin
            regs_q[waddr] <= wdata;
        end
    end

    assign rdata_a = regs_q[raddr_a];
    assign rdata_b = regs_q[raddr_b];
    assign rdata_c = regs_q[raddr_c];

endmodule

// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - four-state fetch/decode/exec/writeback sequencer around an external ALU
module alu_sequencer
    import alu_sequencer_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               instr_valid,
    output logic               instr_ready,
    input  logic [INSTR_W-1:0] instr,
    input  logic               wr_en,
    input  logic [ADDR_W-1:0]  wr_addr,
    input  logic [DATA_W-1:0]  wr_data,
    input  logic [ADDR_W-1:0]  dbg_addr,
    output logic [DATA_W-1:0]  dbg_data,
    output logic [3:0]         opcode,
    output logic [3:0]         d,
    output logic [DATA_W-1:0]  alu_in_a,
    output logic [DATA_W-1:0]  alu_in_b,
    input  logic [DATA_W-1:0]  alu_out,
    input  logic               S,
    input  logic               Z,
    input  logic               C,
    input  logic               V,
    output logic [3:0]         flags,
    output logic               done,
    output logic               illegal
);

    state_e             state_q;
    logic [INSTR_W-1:0] instr_q;
    logic [3:0]         opcode_q;
    logic [3:0]         d_q;
    logic [DATA_W-1:0]  alu_a_q;
    logic [DATA_W-1:0]  alu_b_q;
    logic [DATA_W-1:0]  res_q;
    logic [3:0]         res_flags_q;
    logic [3:0]         flags_q;
    logic               done_q;
    logic               illegal_q;

    logic [ADDR_W-1:0]  ra;
    logic [ADDR_W-1:0]  rb;
    logic [DATA_W-1:0]  rd_a;
    logic [DATA_W-1:0]  rd_b;
    wb_kind_e           wb_kind;
    logic               rf_we;
    logic [ADDR_W-1:0]  rf_waddr;
    logic [DATA_W-1:0]  rf_wdata;
    logic               instr_rsvd_unused;

    assign ra      = instr_q[RA_MSB:RA_LSB];
    assign rb      = instr_q[RB_MSB:RB_LSB];
    assign wb_kind = classify_op(instr_q[OP_MSB:OP_LSB]);

    assign instr_rsvd_unused = ^instr_q[D_LSB-1:0];

    // An external write in IDLE takes the cycle, so the instruction waits.
    assign instr_ready = (state_q == ST_IDLE) && !wr_en;

    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = wr_addr;
        rf_wdata = wr_data;
        if (state_q == ST_IDLE) begin
            rf_we = wr_en;
        end else if (state_q == ST_WB && wb_kind == WB_REG_FLAGS) begin
            rf_we    = 1'b1;
            rf_waddr = ra;
            rf_wdata = res_q;
        end
    end

    alu_regfile u_regfile (
        .clk     (clk),
        .rst     (rst),
        .we      (rf_we),
        .waddr   (rf_waddr),
        .wdata   (rf_wdata),
        .raddr_a (ra),
        .rdata_a (rd_a),
        .raddr_b (rb),
        .rdata_b (rd_b),
        .raddr_c (dbg_addr),
        .rdata_c (dbg_data)
    );

    // The ALU-facing registers double as the operand latches: loaded leaving DECODE, cleared leaving EXEC.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            instr_q     <= '0;
            opcode_q    <= OP_IDLE;
            d_q         <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            res_q       <= '0;
            res_flags_q <= '0;
            flags_q     <= '0;
            done_q      <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (instr_valid && instr_ready) begin
                        instr_q <= instr;
                        state_q <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    opcode_q <= instr_q[OP_MSB:OP_LSB];
                    d_q      <= instr_q[D_MSB:D_LSB];
                    alu_a_q  <= rd_a;
                    alu_b_q  <= rd_b;
                    state_q  <= ST_EXEC;
                end
                ST_EXEC: begin
                    res_q       <= alu_out;
                    res_flags_q <= {S, Z, C, V};
                    opcode_q    <= OP_IDLE;
                    d_q         <= '0;
                    alu_a_q     <= '0;
                    alu_b_q     <= '0;
                    done_q      <= 1'b1;
                    illegal_q   <= (wb_kind == WB_ILLEGAL);
                    state_q     <= ST_WB;
                end
                ST_WB: begin
                    if (wb_kind != WB_ILLEGAL) begin
                        flags_q <= res_flags_q;
                    end
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign opcode   = opcode_q;
    assign d        = d_q;
    assign alu_in_a = alu_a_q;
    assign alu_in_b = alu_b_q;
    assign flags    = flags_q;
    assign done     = done_q;
    assign illegal  = illegal_q;

endmodule
